// File: rtl/control_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : control_sequencer_pkg
//  Purpose  : Shared MiniSRC ISA / ALU definitions for the control sequencer,
//             the datapath and the bench: opcode constants, ALU control codes,
//             instruction field positions, FSM state encoding and the
//             registered control-word layout.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package control_sequencer_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 4;

  // Instruction field positions
  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;

  // Opcodes
  localparam logic [4:0] OP_LD   = 5'h00;
  localparam logic [4:0] OP_ST   = 5'h02;
  localparam logic [4:0] OP_ADD  = 5'h03;
  localparam logic [4:0] OP_SUB  = 5'h04;
  localparam logic [4:0] OP_AND  = 5'h05;
  localparam logic [4:0] OP_OR   = 5'h06;
  localparam logic [4:0] OP_SHR  = 5'h07;
  localparam logic [4:0] OP_SHL  = 5'h08;
  localparam logic [4:0] OP_ROR  = 5'h09;
  localparam logic [4:0] OP_ROL  = 5'h0A;
  localparam logic [4:0] OP_ADDI = 5'h0C;
  localparam logic [4:0] OP_ANDI = 5'h0D;
  localparam logic [4:0] OP_ORI  = 5'h0E;
  localparam logic [4:0] OP_NOP  = 5'h1A;
  localparam logic [4:0] OP_HALT = 5'h1B;

  // ALU control codes
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_SHR = 4'h4;
  localparam logic [3:0] ALU_SHL = 4'h5;
  localparam logic [3:0] ALU_ROR = 4'h6;
  localparam logic [3:0] ALU_ROL = 4'h7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WBL    = 3'd5,
    ST_WB     = 3'd6,
    ST_HALT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU_R   = 3'd0,
    CLS_ALU_I   = 3'd1,
    CLS_LD      = 3'd2,
    CLS_ST      = 3'd3,
    CLS_NOP     = 3'd4,
    CLS_HALT    = 3'd5,
    CLS_ILLEGAL = 3'd6
  } instr_class_t;

  // Registered control word; every field is a Moore output of the state.
  typedef struct packed {
    logic             mem_read;
    logic             mem_write;
    logic             pc_en;
    logic             rf_write;
    logic [REG_W-1:0] rf_addr_a;
    logic [REG_W-1:0] rf_addr_b;
    logic [REG_W-1:0] rf_addr_c;
    logic             rwb_en;
    logic             ra_en;
    logic             rb_en;
    logic             rzh_en;
    logic             rzl_en;
    logic [3:0]       alu_ctrl;
    logic             mux_bis;
    logic             mux_wbm;
    logic             mux_map;
    logic [DATA_W-1:0] imm32;
    logic             halted;
    logic             illegal;
  } ctrl_t;

  function automatic logic [4:0] f_op(input logic [DATA_W-1:0] ir);
    return ir[OP_HI:OP_LO];
  endfunction

  function automatic logic [REG_W-1:0] f_ra(input logic [DATA_W-1:0] ir);
    return ir[RA_HI:RA_LO];
  endfunction

  function automatic logic [REG_W-1:0] f_rb(input logic [DATA_W-1:0] ir);
    return ir[RB_HI:RB_LO];
  endfunction

  function automatic logic [REG_W-1:0] f_rc(input logic [DATA_W-1:0] ir);
    return ir[RC_HI:RC_LO];
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : control_sequencer_if
//  Purpose  : Memory read/write handshake between the control sequencer and
//             the instruction/data memory.
//  Signals  : iMemData  32  read data (instruction or load data)
//             iMemRdy    1  memory completes the current access this cycle
//             oMemRead   1  read strobe, held until iMemRdy
//             oMemWrite  1  write strobe, held until iMemRdy
//  Modports : master = sequencer side, slave = memory side
//  Revision : 1.0 - initial release
// ============================================================================
interface control_sequencer_if;
  import control_sequencer_pkg::*;

  logic [DATA_W-1:0] iMemData;
  logic              iMemRdy;
  logic              oMemRead;
  logic              oMemWrite;

  modport master (
    input  iMemData,
    input  iMemRdy,
    output oMemRead,
    output oMemWrite
  );

  modport slave (
    output iMemData,
    output iMemRdy,
    input  oMemRead,
    input  oMemWrite
  );
endinterface
`default_nettype wire

// File: rtl/control_sequencer_instr_decode.sv
`default_nettype none
// ============================================================================
//  Module   : instr_decode
//  Purpose  : Combinational map from an instruction word to its class, ALU
//             operation, immediate-operand select, sign-extended immediate and
//             an illegal-opcode flag.
//  Ports    : ir        in  32  instruction word
//             cls       out  3  instruction class
//             alu_ctrl  out  4  ALU operation (ld/st use ADD for addressing)
//             use_imm   out  1  B operand comes from the immediate
//             imm32     out 32  sign-extended C field
//             illegal   out  1  opcode not recognised
//  Revision : 1.0 - initial release
// ============================================================================
module instr_decode
  import control_sequencer_pkg::*;
#(
  parameter int IMM_W = 19
) (
  input  logic [DATA_W-1:0] ir,
  output instr_class_t      cls,
  output logic [3:0]        alu_ctrl,
  output logic              use_imm,
  output logic [DATA_W-1:0] imm32,
  output logic              illegal
);

  assign imm32 = {{(DATA_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};

  always_comb begin
    cls      = CLS_NOP;
    alu_ctrl = ALU_ADD;
    use_imm  = 1'b0;
    illegal  = 1'b0;
    case (f_op(ir))
      OP_LD:   begin cls = CLS_LD;    use_imm = 1'b1; end
      OP_ST:   begin cls = CLS_ST;    use_imm = 1'b1; end
      OP_ADD:  begin cls = CLS_ALU_R; alu_ctrl = ALU_ADD; end
      OP_SUB:  begin cls = CLS_ALU_R; alu_ctrl = ALU_SUB; end
      OP_AND:  begin cls = CLS_ALU_R; alu_ctrl = ALU_AND; end
      OP_OR:   begin cls = CLS_ALU_R; alu_ctrl = ALU_OR;  end
      OP_SHR:  begin cls = CLS_ALU_R; alu_ctrl = ALU_SHR; end
      OP_SHL:  begin cls = CLS_ALU_R; alu_ctrl = ALU_SHL; end
      OP_ROR:  begin cls = CLS_ALU_R; alu_ctrl = ALU_ROR; end
      OP_ROL:  begin cls = CLS_ALU_R; alu_ctrl = ALU_ROL; end
      OP_ADDI: begin cls = CLS_ALU_I; alu_ctrl = ALU_ADD; use_imm = 1'b1; end
      OP_ANDI: begin cls = CLS_ALU_I; alu_ctrl = ALU_AND; use_imm = 1'b1; end
      OP_ORI:  begin cls = CLS_ALU_I; alu_ctrl = ALU_OR;  use_imm = 1'b1; end
      OP_NOP:  cls = CLS_NOP;
      OP_HALT: cls = CLS_HALT;
      default: begin cls = CLS_ILLEGAL; illegal = 1'b1; end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : control_sequencer
//  Purpose  : Hardwired MiniSRC control unit. Owns the instruction register
//             and steps each instruction through T0..T4 (FETCH, DECODE, EXEC,
//             MEM or WBL, WB), driving the datapath controls as registered
//             Moore outputs, with a memory-ready handshake and wait timeout.
//  Ports    : iClk, nRst            clock / synchronous active-low reset
//             iRun                  leave IDLE and start fetching
//             mem (master)          memory data/ready in, read/write strobes out
//             oPC_*                 PC controls (jmp/loadRA/loadImm tied 0)
//             oRF_*                 register-file write and addresses
//             oR*_en                datapath register enables (oRAS_en tied 0)
//             oALU_Ctrl             ALU operation
//             oMUX_*                datapath mux selects
//             oImm32, oIR           sign-extended immediate, instruction reg
//             oHalted, oFault       halt executed, sticky memory timeout
//             oIllegal              one-cycle pulse on an unknown opcode
//  Revision : 1.0 - initial release
// ============================================================================
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int IMM_W       = 19
) (
  input  logic              iClk,
  input  logic              nRst,
  input  logic              iRun,
  control_sequencer_if.master mem,
  output logic              oPC_en,
  output logic              oPC_jmp,
  output logic              oPC_loadRA,
  output logic              oPC_loadImm,
  output logic              oRF_Write,
  output logic [REG_W-1:0]  oRF_AddrA,
  output logic [REG_W-1:0]  oRF_AddrB,
  output logic [REG_W-1:0]  oRF_AddrC,
  output logic              oRWB_en,
  output logic              oRA_en,
  output logic              oRB_en,
  output logic              oRZH_en,
  output logic              oRZL_en,
  output logic              oRAS_en,
  output logic [3:0]        oALU_Ctrl,
  output logic              oMUX_BIS,
  output logic              oMUX_RZHS,
  output logic              oMUX_WBM,
  output logic              oMUX_WBP,
  output logic              oMUX_MAP,
  output logic              oMUX_ASS,
  output logic [DATA_W-1:0] oImm32,
  output logic [DATA_W-1:0] oIR,
  output logic              oHalted,
  output logic              oFault,
  output logic              oIllegal
);

  // The wait counter only needs to reach MEM_TIMEOUT-1: the cycle that would
  // make it MEM_TIMEOUT is the one that faults instead.
  localparam int              CNT_W      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit              TIMEOUT_EN = (MEM_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t            state, state_next;
  logic [DATA_W-1:0] ir, ir_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              fault, fault_next;
  logic              mem_wait, timed_out;
  ctrl_t             ctl, ctl_next;

  instr_class_t      dec_cls;
  logic [3:0]        dec_alu;
  logic              dec_use_imm;
  logic [DATA_W-1:0] dec_imm32;
  logic              dec_illegal;

  // IR captures the instruction on the completing fetch cycle only.
  assign ir_next = (state == ST_FETCH && mem.iMemRdy) ? mem.iMemData : ir;

  // Decoding the next IR lets DECODE-phase outputs be registered on the same
  // edge that loads the IR; in every other state ir_next equals ir.
  instr_decode #(
    .IMM_W (IMM_W)
  ) u_instr_decode (
    .ir       (ir_next),
    .cls      (dec_cls),
    .alu_ctrl (dec_alu),
    .use_imm  (dec_use_imm),
    .imm32    (dec_imm32),
    .illegal  (dec_illegal)
  );

  // Next state, wait counter and fault
  always_comb begin
    state_next = state;
    fault_next = fault;
    cnt_next   = '0;
    timed_out  = 1'b0;
    mem_wait   = (state == ST_FETCH || state == ST_MEM) && !mem.iMemRdy;

    if (mem_wait && TIMEOUT_EN) begin
      if (cnt == CNT_LAST) begin
        timed_out = 1'b1;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end

    unique case (state)
      ST_IDLE: begin
        if (iRun) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem.iMemRdy) begin
          state_next = ST_DECODE;
        end else if (timed_out) begin
          state_next = ST_HALT;
          fault_next = 1'b1;
        end
      end
      ST_DECODE: begin
        unique case (dec_cls)
          CLS_ALU_R, CLS_ALU_I, CLS_LD, CLS_ST: state_next = ST_EXEC;
          CLS_HALT:                             state_next = ST_HALT;
          default:                              state_next = ST_FETCH;
        endcase
      end
      ST_EXEC: begin
        state_next = (dec_cls == CLS_LD || dec_cls == CLS_ST) ? ST_MEM : ST_WBL;
      end
      ST_MEM: begin
        if (mem.iMemRdy) begin
          state_next = (dec_cls == CLS_LD) ? ST_WB : ST_FETCH;
        end else if (timed_out) begin
          state_next = ST_HALT;
          fault_next = 1'b1;
        end
      end
      ST_WBL:  state_next = ST_WB;
      ST_WB:   state_next = ST_FETCH;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IDLE;
    endcase
  end

  // Control word for the state being entered
  always_comb begin
    ctl_next = '0;
    unique case (state_next)
      ST_FETCH: begin
        ctl_next.mem_read = 1'b1;
        ctl_next.mux_map  = 1'b1;
      end
      ST_DECODE: begin
        // DECODE is only ever entered from a completed fetch.
        ctl_next.pc_en     = 1'b1;
        ctl_next.rf_addr_a = f_rb(ir_next);
        ctl_next.rf_addr_b = f_rc(ir_next);
        ctl_next.ra_en     = 1'b1;
        ctl_next.rb_en     = 1'b1;
        ctl_next.mux_bis   = dec_use_imm;
        ctl_next.imm32     = dec_imm32;
        ctl_next.illegal   = dec_illegal;
      end
      ST_EXEC: begin
        ctl_next.alu_ctrl = dec_alu;
        ctl_next.rzh_en   = 1'b1;
        ctl_next.rzl_en   = 1'b1;
      end
      ST_MEM: begin
        if (dec_cls == CLS_LD) begin
          ctl_next.mem_read = 1'b1;
          ctl_next.mux_wbm  = 1'b1;
        end else begin
          ctl_next.rf_addr_b = f_ra(ir_next);
          ctl_next.mem_write = 1'b1;
        end
      end
      ST_WBL: ctl_next.rwb_en = 1'b1;
      ST_WB: begin
        ctl_next.rf_addr_c = f_ra(ir_next);
        ctl_next.rf_write  = 1'b1;
      end
      ST_HALT: ctl_next.halted = 1'b1;
      default: ctl_next = '0;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!nRst) begin
      state <= ST_IDLE;
      ir    <= '0;
      cnt   <= '0;
      fault <= 1'b0;
      ctl   <= '0;
    end else begin
      state <= state_next;
      ir    <= ir_next;
      cnt   <= cnt_next;
      fault <= fault_next;
      ctl   <= ctl_next;
    end
  end

  assign mem.oMemRead  = ctl.mem_read;
  assign mem.oMemWrite = ctl.mem_write;

  assign oPC_en      = ctl.pc_en;
  assign oPC_jmp     = 1'b0;
  assign oPC_loadRA  = 1'b0;
  assign oPC_loadImm = 1'b0;
  assign oRF_Write   = ctl.rf_write;
  assign oRF_AddrA   = ctl.rf_addr_a;
  assign oRF_AddrB   = ctl.rf_addr_b;
  assign oRF_AddrC   = ctl.rf_addr_c;
  // Load data is only valid on the ready cycle, so the write-back register
  // capture for ld is qualified by iMemRdy directly (mux_wbm marks ld-MEM).
  assign oRWB_en     = ctl.rwb_en | (ctl.mux_wbm & mem.iMemRdy);
  assign oRA_en      = ctl.ra_en;
  assign oRB_en      = ctl.rb_en;
  assign oRZH_en     = ctl.rzh_en;
  assign oRZL_en     = ctl.rzl_en;
  assign oRAS_en     = 1'b0;
  assign oALU_Ctrl   = ctl.alu_ctrl;
  assign oMUX_BIS    = ctl.mux_bis;
  assign oMUX_RZHS   = 1'b0;
  assign oMUX_WBM    = ctl.mux_wbm;
  assign oMUX_WBP    = 1'b0;
  assign oMUX_MAP    = ctl.mux_map;
  assign oMUX_ASS    = 1'b0;
  assign oImm32      = ctl.imm32;
  assign oIR         = ir;
  assign oHalted     = ctl.halted;
  assign oFault      = fault;
  assign oIllegal    = ctl.illegal;

endmodule
`default_nettype wire

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Hardwired control unit that drives the Datapath control inputs for a MiniSRC core. It owns the instruction register and steps each instruction through fetch, decode, execute, memory and write-back phases (T0..T4), with a ready handshake on memory accesses. It sits directly upstream of the Datapath and replaces hand-driven bench stimulus. Supported instructions: R-type ALU, I-type ALU, ld, st, nop, halt.

Parameters:
MEM_TIMEOUT, 255, memory-wait cycles before fault; 0 disables the timeout.
IMM_W, 19, width of the C immediate field, sign-extended to 32 bits.

Ports:
iClk  in  1  clock, rising edge
nRst  in  1  synchronous active-low reset, sampled on iClk rising edge
iRun  in  1  leave IDLE and start fetching
iMemData  in  32  memory read data (instruction or load data)
iMemRdy  in  1  memory completes the current read/write this cycle
oMemRead / oMemWrite  out  1  memory strobes, held until iMemRdy
oPC_en, oPC_jmp, oPC_loadRA, oPC_loadImm  out  1  PC control; jmp/loadRA/loadImm held 0
oRF_Write  out  1  register-file write
oRF_AddrA, oRF_AddrB, oRF_AddrC  out  4  register-file addresses
oRWB_en, oRA_en, oRB_en, oRZH_en, oRZL_en, oRAS_en  out  1  datapath register enables; oRAS_en held 0
oALU_Ctrl  out  4  ALU operation code (shared ALU header)
oMUX_BIS, oMUX_RZHS, oMUX_WBM, oMUX_WBP, oMUX_MAP, oMUX_ASS  out  1  datapath mux selects
oImm32  out  32  sign-extended immediate
oIR  out  32  instruction register
oHalted  out  1  halt executed
oFault  out  1  memory timeout; sticky
oIllegal  out  1  one-cycle pulse on unknown opcode

Behaviour:
- Instruction fields: op=IR[31:27], Ra=IR[26:23] (dest / store source), Rb=IR[22:19], Rc=IR[18:15], C=IR[18:0].
- Reset: all outputs 0, IR=0, state IDLE, timeout counter 0. Reset wins over every other event, including mid-memory-access: strobes drop in the same edge.
- Outputs are registered Moore outputs, decoded from the state and IR. Every enable is high for exactly the cycle(s) spent in its state.
- IDLE: all controls 0. Goes to FETCH when iRun=1.
- FETCH (T0): oMUX_MAP=1, oMemRead=1. On iMemRdy: IR<=iMemData, oPC_en pulses 1 cycle, go to DECODE. Otherwise stay in FETCH.
- DECODE (T1): oRF_AddrA=Rb, oRF_AddrB=Rc, oRA_en=oRB_en=1. oMUX_BIS=1 for I-type/ld/st, otherwise 0. oImm32=sext(C). Unknown opcode: pulse oIllegal, treat as nop, go to FETCH. nop goes to FETCH. halt goes to HALT.
- EXEC (T2): oALU_Ctrl from the opcode; ld/st use ADD. oRZH_en=oRZL_en=1, oMUX_RZHS=0, oMUX_ASS=0. ALU ops go to WBL; ld/st go to MEM.
- MEM (T3m): oMUX_MAP=0, so the address comes from the ALU result.
  - ld: oMemRead=1, oMUX_WBM=1, oRWB_en=1 on the iMemRdy cycle, then go to WB.
  - st: oRF_AddrB=Ra, oMemWrite=1; on iMemRdy go to FETCH.
- WBL (T3): oRWB_en=1, oMUX_WBM=0, oMUX_WBP=0; go to WB.
- WB (T4): oRF_AddrC=Ra, oRF_Write=1 for one cycle; go to FETCH. A write to R0 is permitted.
- HALT: oHalted=1, all strobes 0. Only reset exits HALT.
- Latency in cycles, with zero-wait memory: ALU op = 5 (T0..T4), ld = 5, st = 4, nop = 2.
- Timeout:
  - The counter increments each cycle in FETCH or MEM without iMemRdy and clears on iMemRdy or on state exit.
  - Reaching MEM_TIMEOUT sets oFault, drops the strobes and enters HALT.
  - iMemRdy arriving in the same cycle as the limit counts as success; no fault.
- iMemRdy outside FETCH/MEM is ignored.
- iRun is ignored outside IDLE.

Decomposition:
- Shared headers carry the opcode constants, the ALU control codes, the state encoding and the field bit positions. The Datapath and bench use the same ISA/ALU definitions.
- One sub-module, instr_decode: a combinational map from IR to {class, aluCtrl, useImm, imm32, illegal}. The FSM and registered outputs stay in control_sequencer.

Test Plan:
- Reset with iRun=0 → all outputs 0, state IDLE. Assert iRun, then iMemRdy=1 with sub R4,R3,R7 → exact T0..T4 sequence; WB cycle has oRF_AddrC=4 and oRF_Write=1; oPC_en pulsed once.
- addi R2,R1,-5 → DECODE oMUX_BIS=1 and oImm32=32'hFFFFFFFB; EXEC oALU_Ctrl=ADD.
- ld R5,8(R1) with iMemRdy delayed 3 cycles → oMemRead held 3+1 cycles, oMUX_MAP=0; oRWB_en with oMUX_WBM=1 only on the ready cycle; then oRF_Write to R5.
- st R6,0(R2) → MEM has oRF_AddrB=6 and oMemWrite until iMemRdy; no oRF_Write; next state FETCH.
- MEM_TIMEOUT=4 with iMemRdy never asserted in FETCH → oFault=1 and oHalted=1 after 4 wait cycles, strobes 0. Also cover nRst=0 asserted mid-MEM → all outputs 0 on the next edge.
- Opcode 5'h1F unknown → a single-cycle oIllegal, no register write, next FETCH. halt → oHalted stays 1 while iRun toggles.
